// File: rtl/sprite_mover.sv
// Fixed-point sprite motion with per-axis acceleration, frame clamping and hit/respawn blinking; outputs registered.
// Vertical motion is compiled in only when SPRITE_MOVER_VERTICAL_EN is defined.
module sprite_mover #(
    parameter int INITIAL_X     = 320,
    parameter int INITIAL_Y     = 450,
    parameter int FRAC_BITS     = 6,
    parameter int MAX_SPEED     = 128,
    parameter int ACCEL         = 32,
    parameter int SPRITE_W      = 36,
    parameter int SPRITE_H      = 32,
    parameter int FRAME_W       = 640,
    parameter int FRAME_H       = 480,
    parameter int HIT_FRAMES    = 30,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_PERIOD  = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        hit,
    input  logic        right,
    input  logic        left,
    input  logic        up,
    input  logic        down,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        visible,
    output logic        invulnerable,
    output logic [1:0]  state
);
    localparam int PW = 12 + FRAC_BITS;
    localparam int VW = $clog2(MAX_SPEED + 1) + 1;
    localparam int CW = $clog2(((HIT_FRAMES > INVULN_FRAMES) ? HIT_FRAMES : INVULN_FRAMES) + 1);
    localparam int BW = $clog2(BLINK_PERIOD + 1);

    localparam logic signed [PW-1:0] INIT_X_FP = PW'(INITIAL_X << FRAC_BITS);
    localparam logic signed [PW-1:0] INIT_Y_FP = PW'(INITIAL_Y << FRAC_BITS);
    localparam logic signed [PW-1:0] MAX_X_FP  = PW'((FRAME_W - SPRITE_W) << FRAC_BITS);
    localparam logic signed [PW-1:0] MAX_Y_FP  = PW'((FRAME_H - SPRITE_H) << FRAC_BITS);
    localparam logic signed [VW+1:0] VMAX      = (VW+2)'(MAX_SPEED);
    localparam logic signed [VW+1:0] ACC       = (VW+2)'(ACCEL);

    typedef enum logic [1:0] {ALIVE = 2'b00, HIT = 2'b01, RESPAWN = 2'b10} state_t;

    state_t                 state_q, state_d;
    logic signed [PW-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [VW-1:0]   vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic [CW-1:0]          frame_cnt_q, frame_cnt_d;
    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   visible_q, visible_d;
    logic                   invuln_q, invuln_d;

    logic signed [VW-1:0]   vx_step, vy_step, mv_vel_x, mv_vel_y;
    logic signed [PW-1:0]   sum_x, sum_y, mv_pos_x, mv_pos_y;

    // Move velocity toward the requested target, landing exactly on it.
    function automatic logic signed [VW-1:0] step_vel(input logic signed [VW-1:0] v,
                                                      input logic pos_req,
                                                      input logic neg_req);
        logic signed [VW+1:0] cur, tgt, nxt;
        cur = {{2{v[VW-1]}}, v};
        if (pos_req && !neg_req)
            tgt = VMAX;
        else if (neg_req && !pos_req)
            tgt = -VMAX;
        else
            tgt = '0;
        if (cur < tgt)
            nxt = ((tgt - cur) > ACC) ? cur + ACC : tgt;
        else if (cur > tgt)
            nxt = ((cur - tgt) > ACC) ? cur - ACC : tgt;
        else
            nxt = tgt;
        return nxt[VW-1:0];
    endfunction

    always_comb begin
        vx_step  = step_vel(vel_x_q, right, left);
        sum_x    = pos_x_q + {{(PW-VW){vx_step[VW-1]}}, vx_step};
        mv_pos_x = sum_x;
        mv_vel_x = vx_step;
        if (sum_x < 0) begin
            mv_pos_x = '0;
            mv_vel_x = '0;
        end else if (sum_x > MAX_X_FP) begin
            mv_pos_x = MAX_X_FP;
            mv_vel_x = '0;
        end
    end

`ifdef SPRITE_MOVER_VERTICAL_EN
    always_comb begin
        vy_step  = step_vel(vel_y_q, down, up);
        sum_y    = pos_y_q + {{(PW-VW){vy_step[VW-1]}}, vy_step};
        mv_pos_y = sum_y;
        mv_vel_y = vy_step;
        if (sum_y < 0) begin
            mv_pos_y = '0;
            mv_vel_y = '0;
        end else if (sum_y > MAX_Y_FP) begin
            mv_pos_y = MAX_Y_FP;
            mv_vel_y = '0;
        end
    end
`else
    logic unused_vert;
    assign unused_vert = up ^ down ^ (|MAX_Y_FP);
    always_comb begin
        vy_step  = '0;
        sum_y    = pos_y_q;
        mv_pos_y = sum_y;
        mv_vel_y = vy_step;
    end
`endif

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        vel_x_d     = vel_x_q;
        vel_y_d     = vel_y_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        visible_d   = visible_q;
        invuln_d    = invuln_q;
        case (state_q)
            ALIVE: begin
                // A hit takes priority over a coincident frame pulse.
                if (hit) begin
                    state_d     = HIT;
                    vel_x_d     = '0;
                    vel_y_d     = '0;
                    visible_d   = 1'b0;
                    frame_cnt_d = '0;
                end else if (startOfFrame) begin
                    pos_x_d = mv_pos_x;
                    vel_x_d = mv_vel_x;
                    pos_y_d = mv_pos_y;
                    vel_y_d = mv_vel_y;
                end
            end
            HIT: begin
                if (startOfFrame) begin
                    if (frame_cnt_q == CW'(HIT_FRAMES - 1)) begin
                        state_d     = RESPAWN;
                        pos_x_d     = INIT_X_FP;
                        pos_y_d     = INIT_Y_FP;
                        invuln_d    = 1'b1;
                        visible_d   = 1'b1;
                        frame_cnt_d = '0;
                        blink_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            RESPAWN: begin
                if (startOfFrame) begin
                    pos_x_d = mv_pos_x;
                    vel_x_d = mv_vel_x;
                    pos_y_d = mv_pos_y;
                    vel_y_d = mv_vel_y;
                    if (frame_cnt_q == CW'(INVULN_FRAMES - 1)) begin
                        state_d     = ALIVE;
                        visible_d   = 1'b1;
                        invuln_d    = 1'b0;
                        frame_cnt_d = '0;
                        blink_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        if (blink_cnt_q == BW'(BLINK_PERIOD - 1)) begin
                            blink_cnt_d = '0;
                            visible_d   = ~visible_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ALIVE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ALIVE;
            pos_x_q     <= INIT_X_FP;
            pos_y_q     <= INIT_Y_FP;
            vel_x_q     <= '0;
            vel_y_q     <= '0;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
            visible_q   <= 1'b1;
            invuln_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            vel_x_q     <= vel_x_d;
            vel_y_q     <= vel_y_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            visible_q   <= visible_d;
            invuln_q    <= invuln_d;
        end
    end

    assign topLeftX     = pos_x_q[FRAC_BITS +: 11];
    assign topLeftY     = pos_y_q[FRAC_BITS +: 11];
    assign visible      = visible_q;
    assign invulnerable = invuln_q;
    assign state        = state_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: acceleration table, clamping, hit/respawn blinking, reset and Y axis.
module tb_sprite_mover;
    logic        clk = 1'b0;
    logic        resetN, startOfFrame, hit, right, left, up, down;
    logic [10:0] topLeftX, topLeftY;
    logic        visible, invulnerable;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    sprite_mover dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .hit          (hit),
        .right        (right),
        .left         (left),
        .up           (up),
        .down         (down),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .visible      (visible),
        .invulnerable (invulnerable),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic l;
        int   exp_x;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // One frame: pulse startOfFrame for one clk; outputs are sampled at the following negedge.
    task automatic do_frame(input logic r, input logic l, input logic u, input logic d);
        @(negedge clk);
        right = r; left = l; up = u; down = d;
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int bad;
        vt[0]  = '{1'b1, 1'b0, 320};
        vt[1]  = '{1'b1, 1'b0, 321};
        vt[2]  = '{1'b1, 1'b0, 323};
        vt[3]  = '{1'b1, 1'b0, 325};
        vt[4]  = '{1'b1, 1'b0, 327};
        vt[5]  = '{1'b1, 1'b1, 328};
        vt[6]  = '{1'b1, 1'b1, 329};
        vt[7]  = '{1'b1, 1'b1, 330};
        vt[8]  = '{1'b1, 1'b1, 330};
        vt[9]  = '{1'b0, 1'b1, 329};
        vt[10] = '{1'b0, 1'b1, 328};
        vt[11] = '{1'b0, 1'b1, 327};
        vt[12] = '{1'b0, 1'b1, 325};
        vt[13] = '{1'b0, 1'b0, 323};
        vt[14] = '{1'b0, 1'b0, 322};
        vt[15] = '{1'b0, 1'b0, 322};
        vt[16] = '{1'b0, 1'b0, 322};

        resetN = 1'b0; startOfFrame = 1'b0; hit = 1'b0;
        right = 1'b0; left = 1'b0; up = 1'b0; down = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", topLeftX, 320);
        chk("rst_y", topLeftY, 450);
        chk("rst_state", state, 0);
        chk("rst_vis", visible, 1);
        chk("rst_inv", invulnerable, 0);
        resetN = 1'b1;
        @(negedge clk);
        chk("idle_x", topLeftX, 320);

        for (int i = 0; i < 17; i++) begin
            do_frame(vt[i].r, vt[i].l, 1'b0, 1'b0);
            chk($sformatf("vec%0d_x", i), topLeftX, vt[i].exp_x);
            chk($sformatf("vec%0d_state", i), state, 0);
        end

        bad = 0;
        for (int i = 0; i < 320; i++) begin
            do_frame(1'b1, 1'b0, 1'b0, 1'b0);
            if (topLeftX > 604) bad++;
        end
        chk("sat_right_x", topLeftX, 604);
        chk("sat_right_overshoot", bad, 0);
        do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_right_hold", topLeftX, 604);

        bad = 0;
        for (int i = 0; i < 340; i++) begin
            do_frame(1'b0, 1'b1, 1'b0, 1'b0);
            if (topLeftX > 604) bad++;
        end
        chk("sat_left_x", topLeftX, 0);
        chk("sat_left_negative", bad, 0);
        do_frame(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sat_left_hold", topLeftX, 0);

        for (int i = 0; i < 5; i++) do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk("from_zero_x", topLeftX, 7);

        hit_pulse();
        chk("hit_state", state, 1);
        chk("hit_vis", visible, 0);
        chk("hit_inv", invulnerable, 0);
        chk("hit_x", topLeftX, 7);
        for (int k = 1; k < 30; k++) begin
            do_frame(1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("frozen%0d_x", k), topLeftX, 7);
            chk($sformatf("frozen%0d_state", k), state, 1);
        end
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk("respawn_x", topLeftX, 320);
        chk("respawn_y", topLeftY, 450);
        chk("respawn_state", state, 2);
        chk("respawn_inv", invulnerable, 1);
        chk("respawn_vis", visible, 1);

        for (int k = 1; k < 60; k++) begin
            if (k == 10) begin
                hit_pulse();
                chk("respawn_hit_ignored", state, 2);
            end
            do_frame(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("blink%0d_vis", k), visible, ((k / 4) % 2 == 0) ? 1 : 0);
            chk($sformatf("blink%0d_state", k), state, 2);
            chk($sformatf("blink%0d_inv", k), invulnerable, 1);
        end
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk("alive_state", state, 0);
        chk("alive_vis", visible, 1);
        chk("alive_inv", invulnerable, 0);
        chk("alive_x", topLeftX, 320);

        for (int i = 0; i < 3; i++) do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reaccel_x", topLeftX, 323);

        @(negedge clk);
        right = 1'b1; hit = 1'b1; startOfFrame = 1'b1;
        @(negedge clk);
        hit = 1'b0; startOfFrame = 1'b0;
        chk("hit_sof_x", topLeftX, 323);
        chk("hit_sof_state", state, 1);
        for (int k = 1; k <= 10; k++) do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk("hit10_x", topLeftX, 323);

        @(negedge clk);
        resetN = 1'b0;
        @(posedge clk);
        #1;
        chk("midhit_rst_state", state, 0);
        chk("midhit_rst_vis", visible, 1);
        chk("midhit_rst_inv", invulnerable, 0);
        chk("midhit_rst_x", topLeftX, 320);
        chk("midhit_rst_y", topLeftY, 450);
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < 5; i++) do_frame(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SPRITE_MOVER_VERTICAL_EN
        chk("down_y", topLeftY, 448);
`else
        chk("down_y", topLeftY, 450);
`endif
        chk("down_x", topLeftX, 320);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_mover.md
# sprite_mover

Parametrised fixed-point sprite motion controller, the successor to the fixed-speed player mover in the VGA path. Key inputs drive an accelerating per-axis velocity. Position is clamped to the visible frame. A hit/respawn state machine freezes, hides, re-centres and blinks the sprite. It feeds the sprite drawer and collision logic with registered top-left coordinates plus visibility and invulnerability flags.

## Interface
- INITIAL_X, 320, respawn/reset X in pixels
- INITIAL_Y, 450, respawn/reset Y in pixels
- FRAC_BITS, 6, fractional bits of the position/velocity fixed point
- MAX_SPEED, 128, maximum speed magnitude in fractional units per frame
- ACCEL, 32, velocity change per frame in fractional units; must be >0 and ≤ MAX_SPEED
- SPRITE_W, 36 / SPRITE_H, 32, sprite size in pixels
- FRAME_W, 640 / FRAME_H, 480, screen size in pixels
- HIT_FRAMES, 30, frames frozen after a hit
- INVULN_FRAMES, 60, frames of post-respawn invulnerability
- BLINK_PERIOD, 4, frames per visibility toggle while invulnerable
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-clk pulse per video frame
- hit  in  1  level, sampled on clk; sprite hit by projectile
- right, left, up, down  in  1 each  movement requests; up/down used only with macro
- topLeftX  out  11  registered pixel X = posX >> FRAC_BITS
- topLeftY  out  11  registered pixel Y = posY >> FRAC_BITS
- visible  out  1  sprite must be drawn
- invulnerable  out  1  collisions must be ignored downstream
- state  out  2  00 ALIVE, 01 HIT, 10 RESPAWN

## Operation
- Internal posX/posY are signed, 12+FRAC_BITS bits. velX/velY are signed and wide enough for ±MAX_SPEED.
- Reset values: posX = INITIAL_X<<FRAC_BITS, posY = INITIAL_Y<<FRAC_BITS, vel = 0, state ALIVE, visible 1, invulnerable 0, all counters 0.
- Target velocity per axis:
  - +MAX_SPEED if only right (down) is high.
  - −MAX_SPEED if only left (up) is high.
  - 0 if both or neither are high.
- On each startOfFrame in ALIVE or RESPAWN:
  - vel steps toward target by ACCEL and saturates exactly at target.
  - pos += new vel.
  - Result is clamped to [0, (FRAME_W−SPRITE_W)<<FRAC_BITS], Y analogously.
  - If a clamp occurs, that axis's vel is forced to 0.
- ALIVE → HIT when hit=1 at any clk edge. Entering HIT sets vel=0, visible=0 and clears the frame counter.
- HIT: position is frozen. On the clk edge carrying the HIT_FRAMES-th startOfFrame:
  - pos loads the INITIAL values.
  - State goes to RESPAWN, with invulnerable=1, visible=1, frame and blink counters cleared.
- RESPAWN: movement is enabled.
  - visible toggles after every BLINK_PERIOD startOfFrame pulses.
  - On the INVULN_FRAMES-th pulse: state goes to ALIVE, visible=1, invulnerable=0.
- hit is ignored in HIT and RESPAWN.
- If hit and startOfFrame arrive in the same cycle in ALIVE, hit wins: no movement is applied that frame.

## Timing
- All outputs are registered. Position, visible and state reflect a startOfFrame or hit one clk after the qualifying edge.
- Frame counting is done only on startOfFrame; clk-level hit detection has 1-cycle latency to state.
- resetN assertion at any time, including mid-HIT or mid-RESPAWN, immediately forces all reset values. There is no residual invulnerability.

## Configuration
- SPRITE_MOVER_VERTICAL_EN
  - Defined: up/down drive the Y axis with the same acceleration and clamp rules as X.
  - Undefined: up/down are ignored, velY stays 0, and posY equals INITIAL_Y<<FRAC_BITS at all times.

## Test plan
- Reset, hold right only, 5 frames from X=320 → topLeftX 320, 321, 323, 325, 327 (vel 32, 64, 96, 128, 128).
- Hold right ≥300 frames → topLeftX saturates at 604 exactly, stays there, velX=0; release and press left → X decreases, reaches 0, never negative.
- At full right speed, press left+right together → vel 96, 64, 32, 0 over 4 frames, then X constant.
- One-clk hit pulse in ALIVE → state=01, visible=0, X frozen for 30 frames. Then X=320, Y=450, state=10, invulnerable=1, visible toggles every 4 frames. Hit during this phase is ignored. After 60 frames, state=00, visible=1.
- Assert resetN low at HIT frame 10 → next cycle state=00, visible=1, invulnerable=0, X=320.
- Macro defined, hold down → Y accelerates and clamps at 448. Macro undefined, hold down → Y stays 450.
